add_result_checker: RTL and testbench

//  Receiving end of the adder interface. Samples the operands driven into an

---
 rtl/add_result_checker.sv | 149 ++++++++++++++
 tb/tb_add_result_checker.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_result_checker.sv
// add_result_checker
//   Receiving end of an adder interface. Watches the operand pair driven into an
//   adder and the {carry, answer} it returns LATENCY cycles later, and checks every
//   result against the full-width sum a + b. Counts checks and mismatches, captures
//   the first failing operand pair and gives a pass/fail verdict after NUM_CHECKS
//   checks. Usable beside an adder in simulation or as a synthesizable BIST monitor.
//
// Parameters
//   WIDTH       operand width of input_a / input_b / answer
//   LATENCY     cycles from operand sample to result (0..4); 0 = combinational adder
//   NUM_CHECKS  checks per run, 1 .. 2**CNT_W-1
//   CNT_W       width of the check / error counters
//
// Ports
//   iclk, rst                 clock (rising edge) and synchronous active-high reset
//   start                     one-cycle pulse to begin a run (ignored while busy)
//   valid, input_a, input_b   operand pair as driven to the adder
//   answer, carry             adder result
//   busy, done, pass, fail    run status; pass/fail only meaningful while done
//   check_count, error_count  compares and mismatches in the current run
//   first_err_*               capture of the first mismatch of the run

module add_result_checker #(
    parameter int unsigned WIDTH      = 1,
    parameter int unsigned LATENCY    = 0,
    parameter int unsigned NUM_CHECKS = 16,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             iclk,
    input  logic             rst,
    input  logic             start,
    input  logic             valid,
    input  logic [WIDTH-1:0] input_a,
    input  logic [WIDTH-1:0] input_b,
    input  logic [WIDTH-1:0] answer,
    input  logic             carry,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic [CNT_W-1:0] check_count,
    output logic [CNT_W-1:0] error_count,
    output logic             first_err_vld,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [WIDTH-1:0] first_err_a,
    output logic [WIDTH-1:0] first_err_b
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_t;

    localparam int unsigned PW = 1 + 2 * WIDTH;

    state_t state;

    logic [PW-1:0]    cur_op;
    logic [PW-1:0]    dly_op;
    logic             dly_valid;
    logic [WIDTH-1:0] dly_a;
    logic [WIDTH-1:0] dly_b;
    logic [WIDTH:0]   exp_sum;
    logic             mismatch;
    logic             cmp_event;

    assign cur_op = {valid, input_a, input_b};

    // Operand delay line, aligned with the adder's result latency. It shifts in
    // every state so the alignment is already correct on the first RUN cycle.
    if (LATENCY == 0) begin : g_no_pipe
        assign dly_op = cur_op;
    end else begin : g_pipe
        logic [PW-1:0] pipe [LATENCY];

        always_ff @(posedge iclk) begin
            if (rst) begin
                for (int i = 0; i < int'(LATENCY); i++) begin
                    pipe[i] <= '0;
                end
            end else begin
                pipe[0] <= cur_op;
                for (int i = 1; i < int'(LATENCY); i++) begin
                    pipe[i] <= pipe[i-1];
                end
            end
        end

        assign dly_op = pipe[LATENCY-1];
    end

    assign {dly_valid, dly_a, dly_b} = dly_op;

    // Full-width sum: the carry out is part of the expected result.
    assign exp_sum   = {1'b0, dly_a} + {1'b0, dly_b};
    assign mismatch  = ({carry, answer} != exp_sum);
    assign cmp_event = (state == StRun) && dly_valid;

    always_ff @(posedge iclk) begin
        if (rst) begin
            state         <= StIdle;
            check_count   <= '0;
            error_count   <= '0;
            first_err_vld <= 1'b0;
            first_err_idx <= '0;
            first_err_a   <= '0;
            first_err_b   <= '0;
        end else begin
            unique case (state)
                StIdle, StDone: begin
                    if (start) begin
                        state         <= StRun;
                        check_count   <= '0;
                        error_count   <= '0;
                        first_err_vld <= 1'b0;
                        first_err_idx <= '0;
                        first_err_a   <= '0;
                        first_err_b   <= '0;
                    end
                end
                StRun: begin
                    if (cmp_event) begin
                        check_count <= check_count + 1'b1;
                        if (mismatch) begin
                            error_count <= error_count + 1'b1;
                            if (!first_err_vld) begin
                                first_err_vld <= 1'b1;
                                first_err_idx <= check_count;
                                first_err_a   <= dly_a;
                                first_err_b   <= dly_b;
                            end
                        end
                        if (check_count == CNT_W'(NUM_CHECKS - 1)) begin
                            state <= StDone;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign busy = (state == StRun);
    assign done = (state == StDone);
    assign pass = done && (error_count == '0);
    assign fail = done && (error_count != '0);

endmodule

// File: tb/tb_add_result_checker.sv
module tb_add_result_checker;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Group 1: W=1, L=0, N=16
    logic       s1_start, s1_valid, s1_carry;
    logic [0:0] s1_a, s1_b, s1_ans;
    logic       o1_busy, o1_done, o1_pass, o1_fail, o1_fvld;
    logic [7:0] o1_chk, o1_err, o1_fidx;
    logic [0:0] o1_fa, o1_fb;

    // Group 2: W=4, shared 2-stage registered adder, checked with L=2 and L=1
    logic       s2_start, s2_valid;
    logic [3:0] s2_a, s2_b;
    logic [4:0] sum_s1, sum_s2;
    logic       o2_busy, o2_done, o2_pass, o2_fail, o2_fvld;
    logic [7:0] o2_chk, o2_err, o2_fidx;
    logic [3:0] o2_fa, o2_fb;
    logic       o3_busy, o3_done, o3_pass, o3_fail, o3_fvld;
    logic [7:0] o3_chk, o3_err, o3_fidx;
    logic [3:0] o3_fa, o3_fb;

    // Group 3: W=4, L=0, N=8
    logic       s4_start, s4_valid, s4_carry;
    logic [3:0] s4_a, s4_b, s4_ans;
    logic       o4_busy, o4_done, o4_pass, o4_fail, o4_fvld;
    logic [7:0] o4_chk, o4_err, o4_fidx;
    logic [3:0] o4_fa, o4_fb;

    always @(posedge clk) begin
        sum_s1 <= {1'b0, s2_a} + {1'b0, s2_b};
        sum_s2 <= sum_s1;
    end

    add_result_checker #(.WIDTH(1), .LATENCY(0), .NUM_CHECKS(16), .CNT_W(8)) u_w1 (
        .iclk(clk), .rst(rst), .start(s1_start), .valid(s1_valid), .input_a(s1_a),
        .input_b(s1_b), .answer(s1_ans), .carry(s1_carry), .busy(o1_busy), .done(o1_done),
        .pass(o1_pass), .fail(o1_fail), .check_count(o1_chk), .error_count(o1_err),
        .first_err_vld(o1_fvld), .first_err_idx(o1_fidx), .first_err_a(o1_fa),
        .first_err_b(o1_fb)
    );

    add_result_checker #(.WIDTH(4), .LATENCY(2), .NUM_CHECKS(16), .CNT_W(8)) u_l2 (
        .iclk(clk), .rst(rst), .start(s2_start), .valid(s2_valid), .input_a(s2_a),
        .input_b(s2_b), .answer(sum_s2[3:0]), .carry(sum_s2[4]), .busy(o2_busy),
        .done(o2_done), .pass(o2_pass), .fail(o2_fail), .check_count(o2_chk),
        .error_count(o2_err), .first_err_vld(o2_fvld), .first_err_idx(o2_fidx),
        .first_err_a(o2_fa), .first_err_b(o2_fb)
    );

    add_result_checker #(.WIDTH(4), .LATENCY(1), .NUM_CHECKS(16), .CNT_W(8)) u_l1 (
        .iclk(clk), .rst(rst), .start(s2_start), .valid(s2_valid), .input_a(s2_a),
        .input_b(s2_b), .answer(sum_s2[3:0]), .carry(sum_s2[4]), .busy(o3_busy),
        .done(o3_done), .pass(o3_pass), .fail(o3_fail), .check_count(o3_chk),
        .error_count(o3_err), .first_err_vld(o3_fvld), .first_err_idx(o3_fidx),
        .first_err_a(o3_fa), .first_err_b(o3_fb)
    );

    add_result_checker #(.WIDTH(4), .LATENCY(0), .NUM_CHECKS(8), .CNT_W(8)) u_w4 (
        .iclk(clk), .rst(rst), .start(s4_start), .valid(s4_valid), .input_a(s4_a),
        .input_b(s4_b), .answer(s4_ans), .carry(s4_carry), .busy(o4_busy), .done(o4_done),
        .pass(o4_pass), .fail(o4_fail), .check_count(o4_chk), .error_count(o4_err),
        .first_err_vld(o4_fvld), .first_err_idx(o4_fidx), .first_err_a(o4_fa),
        .first_err_b(o4_fb)
    );

    // Reference model of one run: counts valid results, mismatches and the first failure.
    int   m_chk, m_err, m_fidx;
    logic m_fvld;
    int   m_fa, m_fb;

    task automatic model_clear();
        m_chk = 0; m_err = 0; m_fidx = 0; m_fvld = 1'b0; m_fa = 0; m_fb = 0;
    endtask

    task automatic model_result(input int a, input int b, input int got);
        if (got != a + b) begin
            if (!m_fvld) begin
                m_fvld = 1'b1; m_fidx = m_chk; m_fa = a; m_fb = b;
            end
            m_err++;
        end
        m_chk++;
    endtask

    // Drive one complete 16-check run on group 1.
    // pat: 0 = 00,01,10,11 cycle, 1 = random. fault: 0 none, 1 carry dropped on 1+1,
    // 2 random corruption. toggle: valid alternates. midstart: extra start mid-run.
    task automatic drive_run1(input int pat, input int fault, input int toggle,
                              input int midstart);
        int cyc;
        logic v;
        logic a, b;
        logic [1:0] sum, got;
        model_clear();
        @(negedge clk);
        s1_start = 1'b1; s1_valid = 1'b0;
        cyc = 0;
        while (m_chk < 16 && cyc < 200) begin
            @(negedge clk);
            s1_start = (midstart != 0 && m_chk == 5) ? 1'b1 : 1'b0;
            v = (toggle != 0) ? ((cyc % 2) == 0) : 1'b1;
            if (pat == 0) {a, b} = 2'(m_chk % 4);
            else {a, b} = 2'($urandom);
            sum = {1'b0, a} + {1'b0, b};
            got = sum;
            if (fault == 1 && a && b) got[1] = 1'b0;
            if (fault == 2 && $urandom_range(3) == 0) got = sum ^ 2'($urandom_range(3, 1));
            if (!v) got = 2'($urandom);
            s1_valid = v; s1_a = a; s1_b = b; {s1_carry, s1_ans} = got;
            if (v) model_result(int'(a), int'(b), int'(got));
            cyc++;
        end
        @(negedge clk);
        s1_valid = 1'b0; s1_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s1_start = 1'b1; s1_valid = 1'b1; s1_a = 1'b1; s1_b = 1'b1; s1_ans = 1'b0;
        s1_carry = 1'b0;
        s2_start = 1'b0; s2_valid = 1'b0; s2_a = '0; s2_b = '0;
        s4_start = 1'b1; s4_valid = 1'b1; s4_a = 4'hF; s4_b = 4'h1; s4_ans = 4'h3;
        s4_carry = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({o1_busy, o1_done, o1_pass, o1_fail, o1_fvld} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags_w1: got %b expected 00000",
                     {o1_busy, o1_done, o1_pass, o1_fail, o1_fvld});
        end
        checks++;
        if ({o1_chk, o1_err, o1_fidx, o1_fa, o1_fb} !== 26'b0) begin
            errors++;
            $display("FAIL reset_regs_w1: chk=%0d err=%0d idx=%0d a=%0d b=%0d expected all 0",
                     o1_chk, o1_err, o1_fidx, o1_fa, o1_fb);
        end
        checks++;
        if ({o4_busy, o4_done, o4_fvld, o4_chk, o4_err, o4_fidx, o4_fa, o4_fb} !== 35'b0) begin
            errors++;
            $display("FAIL reset_w4: busy=%b done=%b chk=%0d err=%0d expected all 0",
                     o4_busy, o4_done, o4_chk, o4_err);
        end
        rst = 1'b0; s1_start = 1'b0; s1_valid = 1'b0; s4_start = 1'b0; s4_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (o1_busy !== 1'b0 || o1_chk !== 8'd0) begin
            errors++;
            $display("FAIL idle_no_compare: busy=%b chk=%0d expected 0 0", o1_busy, o1_chk);
        end
    endtask

    task automatic check_run1(input string name);
        checks++;
        if (o1_done !== 1'b1 || o1_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_done: done=%b busy=%b expected 1 0", name, o1_done, o1_busy);
        end
        checks++;
        if (o1_chk !== 8'(m_chk) || o1_err !== 8'(m_err)) begin
            errors++;
            $display("FAIL %s_counts: chk=%0d err=%0d expected %0d %0d",
                     name, o1_chk, o1_err, m_chk, m_err);
        end
        checks++;
        if (o1_pass !== (m_err == 0) || o1_fail !== (m_err != 0)) begin
            errors++;
            $display("FAIL %s_verdict: pass=%b fail=%b expected %b %b",
                     name, o1_pass, o1_fail, m_err == 0, m_err != 0);
        end
        checks++;
        if (o1_fvld !== m_fvld) begin
            errors++;
            $display("FAIL %s_fvld: got %b expected %b", name, o1_fvld, m_fvld);
        end
        if (m_fvld) begin
            checks++;
            if (o1_fidx !== 8'(m_fidx) || o1_fa !== 1'(m_fa) || o1_fb !== 1'(m_fb)) begin
                errors++;
                $display("FAIL %s_capture: idx=%0d a=%0d b=%0d expected %0d %0d %0d",
                         name, o1_fidx, o1_fa, o1_fb, m_fidx, m_fa, m_fb);
            end
        end
    endtask

    task automatic test_half_adder();
        drive_run1(0, 0, 0, 0);
        check_run1("half_adder");
    endtask

    task automatic test_carry_fault();
        drive_run1(0, 1, 0, 0);
        check_run1("carry_fault");
    endtask

    task automatic test_back_to_back();
        // Results arriving in DONE must be dropped.
        repeat (3) begin
            @(negedge clk);
            s1_valid = 1'b1; s1_a = 1'b1; s1_b = 1'b1; s1_ans = 1'b1; s1_carry = 1'b1;
        end
        @(negedge clk);
        s1_valid = 1'b0;
        check_run1("done_hold");
        drive_run1(1, 2, 0, 0);
        check_run1("back_to_back");
    endtask

    task automatic test_valid_toggle();
        drive_run1(1, 0, 1, 1);
        check_run1("valid_toggle");
    endtask

    task automatic test_midrun_reset();
        model_clear();
        @(negedge clk);
        s1_start = 1'b1; s1_valid = 1'b0;
        repeat (5) begin
            @(negedge clk);
            s1_start = 1'b0; s1_valid = 1'b1; s1_a = 1'b1; s1_b = 1'b0;
            s1_ans = 1'b1; s1_carry = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (o1_chk !== 8'd5 || o1_busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: chk=%0d busy=%b expected 5 1", o1_chk, o1_busy);
        end
        rst = 1'b1; s1_start = 1'b1;   // reset wins over start
        @(negedge clk);
        rst = 1'b0; s1_start = 1'b0;
        checks++;
        if (o1_busy !== 1'b0 || o1_chk !== 8'd0 || o1_err !== 8'd0 || o1_done !== 1'b0) begin
            errors++;
            $display("FAIL midrun_reset: busy=%b chk=%0d err=%0d done=%b expected 0 0 0 0",
                     o1_busy, o1_chk, o1_err, o1_done);
        end
        repeat (4) begin
            s1_valid = 1'b1; s1_a = 1'b1; s1_b = 1'b1; s1_ans = 1'b1; s1_carry = 1'b1;
            @(negedge clk);
        end
        s1_valid = 1'b0;
        checks++;
        if (o1_busy !== 1'b0 || o1_chk !== 8'd0 || o1_err !== 8'd0) begin
            errors++;
            $display("FAIL no_compare_after_reset: busy=%b chk=%0d err=%0d expected 0 0 0",
                     o1_busy, o1_chk, o1_err);
        end
        drive_run1(1, 0, 0, 0);
        check_run1("fresh_run");
    endtask

    task automatic test_latency();
        int prev;
        int cyc;
        logic [3:0] a, b;
        @(negedge clk);
        s2_start = 1'b1; s2_valid = 1'b0; s2_a = '0; s2_b = '0;
        prev = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            s2_start = 1'b0;
            a = 4'($urandom); b = 4'($urandom);
            // Consecutive sums differ so a misaligned checker must see mismatches.
            if (int'(a) + int'(b) == prev) a = a + 4'd1;
            prev = int'(a) + int'(b);
            s2_valid = 1'b1; s2_a = a; s2_b = b;
        end
        @(negedge clk);
        s2_valid = 1'b0; s2_a = '0; s2_b = '0;
        cyc = 0;
        while (!(o2_done && o3_done) && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (!(o2_done && o3_done)) begin
            errors++;
            $display("FAIL latency_timeout: done_l2=%b done_l1=%b expected 1 1",
                     o2_done, o3_done);
        end
        checks++;
        if (o2_pass !== 1'b1 || o2_err !== 8'd0 || o2_chk !== 8'd16) begin
            errors++;
            $display("FAIL latency_l2: pass=%b err=%0d chk=%0d expected 1 0 16",
                     o2_pass, o2_err, o2_chk);
        end
        checks++;
        if (o3_err === 8'd0 || o3_fail !== 1'b1) begin
            errors++;
            $display("FAIL latency_l1: err=%0d fail=%b expected err!=0 fail=1",
                     o3_err, o3_fail);
        end
    endtask

    task automatic test_wide(input int inject);
        logic [3:0] a, b;
        logic [4:0] got;
        model_clear();
        @(negedge clk);
        s4_start = 1'b1; s4_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            s4_start = 1'b0;
            if (i == 0 || i == 5) begin
                a = 4'hF; b = 4'hF;
            end else begin
                a = 4'($urandom); b = 4'($urandom);
            end
            got = 5'(int'(a) + int'(b));
            if (inject != 0 && i == 5) got = {1'b1, 4'hF};
            s4_valid = 1'b1; s4_a = a; s4_b = b; {s4_carry, s4_ans} = got;
            model_result(int'(a), int'(b), int'(got));
        end
        @(negedge clk);
        s4_valid = 1'b0;
        checks++;
        if (o4_done !== 1'b1 || o4_chk !== 8'(m_chk) || o4_err !== 8'(m_err)) begin
            errors++;
            $display("FAIL wide_counts_%0d: done=%b chk=%0d err=%0d expected 1 %0d %0d",
                     inject, o4_done, o4_chk, o4_err, m_chk, m_err);
        end
        checks++;
        if (o4_pass !== (m_err == 0) || o4_fail !== (m_err != 0) || o4_fvld !== m_fvld) begin
            errors++;
            $display("FAIL wide_verdict_%0d: pass=%b fail=%b fvld=%b expected %b %b %b",
                     inject, o4_pass, o4_fail, o4_fvld, m_err == 0, m_err != 0, m_fvld);
        end
        if (m_fvld) begin
            checks++;
            if (o4_fidx !== 8'(m_fidx) || o4_fa !== 4'(m_fa) || o4_fb !== 4'(m_fb)) begin
                errors++;
                $display("FAIL wide_capture: idx=%0d a=%0d b=%0d expected %0d %0d %0d",
                         o4_fidx, o4_fa, o4_fb, m_fidx, m_fa, m_fb);
            end
        end
    endtask

    initial begin
        test_reset();
        test_half_adder();
        test_carry_fault();
        test_back_to_back();
        test_valid_toggle();
        test_midrun_reset();
        test_latency();
        test_wide(0);
        test_wide(1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
